// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock/strobe generator.
// Config fields are carried at a fixed width; channels use the low CNT_W bits.
package clk_gen_pkg;

  localparam int CFG_W = 32;
  typedef logic [CFG_W-1:0] cfg_val_t;

  localparam cfg_val_t MIN_PERIOD = cfg_val_t'(2);
  localparam cfg_val_t CFG_ONE    = cfg_val_t'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    cfg_val_t period;
    cfg_val_t high;
    cfg_val_t phase;
  } cfg_t;

  // Clamp a raw config to legal values: period >= 2 and at least one low cycle.
  function automatic cfg_t eff_cfg(input cfg_t raw);
    cfg_t e;
    e = raw;
    if (raw.period < MIN_PERIOD) e.period = MIN_PERIOD;
    if (raw.high > e.period - CFG_ONE) e.high = e.period - CFG_ONE;
    return e;
  endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One generator channel: IDLE/DELAY/RUN/DRAIN FSM, period counter, shadow and
// active configuration, registered clock and rise-pulse outputs.
module clk_gen_chan
  import clk_gen_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic cfg_we_i,
  input  cfg_t cfg_i,
  output logic clk_out_o,
  output logic rise_pulse_o,
  output logic busy_o
);

  localparam cfg_t DEF_CFG = '{period: cfg_val_t'(DEF_PERIOD),
                               high:   cfg_val_t'(DEF_PERIOD / 2),
                               phase:  '0};
  localparam cfg_t DEF_EFF = eff_cfg(DEF_CFG);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cfg_t             shadow_q, shadow_d;
  cfg_t             nxt_eff;
  cfg_val_t         per_q, per_d;
  cfg_val_t         high_q, high_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             last_cycle;
  logic             running_d;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    shadow_d  = cfg_we_i ? cfg_i : shadow_q;
    nxt_eff   = eff_cfg(shadow_d);
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    high_d    = high_q;
    last_cycle = (cfg_val_t'(cnt_q) == per_q - CFG_ONE);

    unique case (state_q)
      IDLE: begin
        per_d  = nxt_eff.period;
        high_d = nxt_eff.high;
        cnt_d  = '0;
        if (enable_i) begin
          if (shadow_d.phase == '0) begin
            state_d = RUN;
          end else begin
            state_d = DELAY;
            cnt_d   = CNT_W'(shadow_d.phase - CFG_ONE);
          end
        end
      end
      DELAY: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RUN, DRAIN: begin
        // A disable seen on the last cycle ends the period right there.
        if (last_cycle) begin
          cnt_d = '0;
          if (enable_i) begin
            state_d = RUN;
            per_d   = nxt_eff.period;
            high_d  = nxt_eff.high;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = enable_i ? RUN : DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    running_d = (state_d == RUN) || (state_d == DRAIN);
    clk_out_d = running_d && (cfg_val_t'(cnt_d) < high_d);
    rise_d    = running_d && (cnt_d == '0);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= DEF_CFG;
      per_q     <= DEF_EFF.period;
      high_q    <= DEF_EFF.high;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      per_q     <= per_d;
      high_q    <= high_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
    end
  end

  assign clk_out_o    = clk_out_q;
  assign rise_pulse_o = rise_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock/strobe generator: decodes config writes to
// per-channel strobes and instantiates one independent channel per output.
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 4,
  localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_high,
  input  logic [CNT_W-1:0]    cfg_phase,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] busy
);

  cfg_t wr_cfg;

  assign wr_cfg = '{period: cfg_val_t'(cfg_period),
                    high:   cfg_val_t'(cfg_high),
                    phase:  cfg_val_t'(cfg_phase)};

  // Selector values with no matching channel simply produce no write strobe.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic chan_we;
    assign chan_we = cfg_we && (cfg_sel == SEL_W'(g));

    clk_gen_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable[g]),
      .cfg_we_i     (chan_we),
      .cfg_i        (wr_cfg),
      .clk_out_o    (clk_out[g]),
      .rise_pulse_o (rise_pulse[g]),
      .busy_o       (busy[g])
    );
  end

endmodule
